// File: rtl/mesh_pkt_pkg.sv
// Mesh packet field layout, header struct and helpers shared by the terminal injector.
// Packet: nxt_jump | row | col | mode | payload, MSB first.
package mesh_pkt_pkg;

  localparam int NXT_W     = 8;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 4;
  localparam int MODE_W    = 1;
  localparam int HDR_W     = NXT_W + ROW_W + COL_W + MODE_W;
  localparam int MAX_PKT_W = 128;

  typedef struct packed {
    logic [NXT_W-1:0] nxt_jump;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             mode;
  } pkt_hdr_t;

  // Terminals sit on the mesh rim: top/bottom rows or left/right columns, corners excluded.
  function automatic logic is_legal_terminal(input logic [ROW_W-1:0] row,
                                             input logic [COL_W-1:0] col,
                                             input int rows,
                                             input int cols);
    int r;
    int c;
    r = int'(row);
    c = int'(col);
    return ((r == 0 || r == rows + 1) && c >= 1 && c <= cols) ||
           ((c == 0 || c == cols + 1) && r >= 1 && r <= rows);
  endfunction

  // Result is right-aligned; callers cast to their packet width.
  function automatic logic [MAX_PKT_W-1:0] build_pkt(input pkt_hdr_t hdr,
                                                     input logic [MAX_PKT_W-1:0] payload,
                                                     input int pw);
    logic [MAX_PKT_W-1:0] mask;
    logic [MAX_PKT_W-1:0] hdr_wide;
    mask     = ~({MAX_PKT_W{1'b1}} << pw);
    hdr_wide = {{(MAX_PKT_W-HDR_W){1'b0}}, hdr};
    return (hdr_wide << pw) | (payload & mask);
  endfunction

endpackage

// File: rtl/mesh_term_injector_if.sv
// Producer-request and mesh-terminal handshake bundle for one injector.
// master drives requests and popin; slave (the injector) answers with wr_rdy and the head packet.
interface mesh_term_injector_if #(
  parameter int pckg_sz = 40
);
  localparam int PW = pckg_sz - 17;

  logic               wr_vld;
  logic               wr_rdy;
  logic [3:0]         wr_row;
  logic [3:0]         wr_col;
  logic               wr_mode;
  logic [PW-1:0]      wr_payload;
  logic [pckg_sz-1:0] data_out_i_in;
  logic               pndng_i_in;
  logic               popin;

  modport master (
    output wr_vld, wr_row, wr_col, wr_mode, wr_payload, popin,
    input  wr_rdy, data_out_i_in, pndng_i_in
  );

  modport slave (
    input  wr_vld, wr_row, wr_col, wr_mode, wr_payload, popin,
    output wr_rdy, data_out_i_in, pndng_i_in
  );

endinterface

// File: rtl/mesh_inj_fifo.sv
// Circular packet store behind the injector head register.
// Latency: pushed data readable at pop_dat the cycle after push.
// Backpressure: push ignored when full unless popping the same cycle; pop ignored when empty.
module mesh_inj_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wp, rp, wp_nxt, rp_nxt;
  logic             full_q;
  logic             do_push, do_pop;

  assign empty   = (wp == rp) && !full_q;
  assign full    = full_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full_q || do_pop);
  assign pop_dat = mem[rp];

  // Pointers wrap at DEPTH, which need not be a power of two.
  assign wp_nxt = (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + PTR_W'(1);
  assign rp_nxt = (rp == PTR_W'(DEPTH - 1)) ? '0 : rp + PTR_W'(1);

  always_comb begin
    count = '0;
    if (full_q)
      count = CNT_W'(DEPTH);
    else if (wp >= rp)
      count = CNT_W'(wp - rp);
    else
      count = CNT_W'(DEPTH + int'(wp) - int'(rp));
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wp] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp     <= '0;
      rp     <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push)
        wp <= wp_nxt;
      if (do_pop)
        rp <= rp_nxt;
      if (do_push && !do_pop)
        full_q <= (wp_nxt == rp);
      else if (do_pop && !do_push)
        full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mesh_term_injector.sv
// Per-terminal mesh packet source: validates, formats and queues producer requests (MESH_INJ_SEQ_STAMP_EN stamps a sequence number).
// Latency: accepted packet reaches pndng_i_in/data_out_i_in one cycle after acceptance.
// Backpressure: wr_rdy drops when fifo_depth packets are held; it depends on registered state only, never on popin.
module mesh_term_injector
  import mesh_pkt_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 8,
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int id_row     = 0,
  parameter int id_column  = 0,
  parameter int SEQ_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  mesh_term_injector_if.slave             bus,
  output logic [$clog2(fifo_depth+1)-1:0] fill_lvl,
  output logic [15:0]                     sent_cnt,
  output logic [15:0]                     rej_cnt,
  output logic                            err_bad_dest
);

  localparam int PW     = pckg_sz - 17;
  localparam int STORE  = fifo_depth - 1;
  localparam int FILL_W = $clog2(fifo_depth + 1);
  localparam int CNT_W  = $clog2(STORE + 1);

  if (fifo_depth < 2 || pckg_sz < 18 || SEQ_W < 1 || SEQ_W >= PW ||
      id_row < 0 || id_row > ROWS + 1 || id_column < 0 || id_column > COLUMS + 1) begin : g_bad_cfg
    $error("mesh_term_injector: illegal parameter combination");
  end

  typedef enum logic {ST_EMPTY, ST_LOADED} head_state_t;

  head_state_t        state;
  logic [pckg_sz-1:0] head_q;
  logic               pndng_q;

  pkt_hdr_t           hdr;
  logic [PW-1:0]      payload_fmt;
  logic [pckg_sz-1:0] pkt;
  logic               legal, fire, push, rej, pop_head;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [pckg_sz-1:0] fifo_rd_dat;
  logic [CNT_W-1:0]   fifo_cnt;

  assign fill_lvl          = FILL_W'(pndng_q) + FILL_W'(fifo_cnt);
  assign bus.wr_rdy        = (fill_lvl != FILL_W'(fifo_depth));
  assign bus.pndng_i_in    = pndng_q;
  assign bus.data_out_i_in = head_q;

  assign legal    = is_legal_terminal(bus.wr_row, bus.wr_col, ROWS, COLUMS);
  assign fire     = bus.wr_vld && bus.wr_rdy;
  assign push     = fire && legal;
  assign rej      = fire && !legal;
  assign pop_head = bus.popin && pndng_q;

`ifdef MESH_INJ_SEQ_STAMP_EN
  logic [SEQ_W-1:0] seq_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      seq_cnt <= '0;
    else if (push)
      seq_cnt <= seq_cnt + SEQ_W'(1);
  end

  always_comb begin
    payload_fmt              = bus.wr_payload;
    payload_fmt[SEQ_W-1:0]   = seq_cnt;
  end
`else
  assign payload_fmt = bus.wr_payload;
`endif

  always_comb begin
    hdr          = '0;
    hdr.nxt_jump = 8'h00;
    hdr.row      = bus.wr_row;
    hdr.col      = bus.wr_col;
    hdr.mode     = bus.wr_mode;
    pkt          = pckg_sz'(build_pkt(hdr, MAX_PKT_W'(payload_fmt), PW));
  end

  // Storage only takes a packet when the head is occupied and not being refilled directly by it.
  assign fifo_push = push && (state == ST_LOADED) && !(bus.popin && fifo_empty);
  assign fifo_pop  = (state == ST_LOADED) && bus.popin && !fifo_empty;

  mesh_inj_fifo #(
    .W     (pckg_sz),
    .DEPTH (STORE)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (pkt),
    .pop      (fifo_pop),
    .pop_dat  (fifo_rd_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      pndng_q <= 1'b0;
      head_q  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head_q  <= pkt;
            pndng_q <= 1'b1;
            state   <= ST_LOADED;
          end
        end
        ST_LOADED: begin
          if (bus.popin) begin
            if (!fifo_empty) begin
              head_q <= fifo_rd_dat;
            end else if (push) begin
              head_q <= pkt;
            end else begin
              pndng_q <= 1'b0;
              state   <= ST_EMPTY;
            end
          end
        end
        default: begin
          pndng_q <= 1'b0;
          state   <= ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_cnt     <= '0;
      rej_cnt      <= '0;
      err_bad_dest <= 1'b0;
    end else begin
      err_bad_dest <= rej;
      if (pop_head && sent_cnt != 16'hFFFF)
        sent_cnt <= sent_cnt + 16'd1;
      if (rej && rej_cnt != 16'hFFFF)
        rej_cnt <= rej_cnt + 16'd1;
    end
  end

  // fifo_full is implied by fill_lvl; kept visible for debug probes.
  logic fifo_full_unused;
  assign fifo_full_unused = fifo_full;

endmodule

// File: tb/tb_mesh_term_injector.sv
// Scoreboard bench for mesh_term_injector: expected packets queued on acceptance, compared when the mesh pops them.
module tb_mesh_term_injector;

  localparam int PKT_W = 40;
  localparam int PW    = 23;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fill_lvl;
  logic [15:0] sent_cnt;
  logic [15:0] rej_cnt;
  logic        err_bad_dest;

  int checks = 0;
  int fails  = 0;

  logic [PKT_W-1:0] exp_q[$];
  logic [7:0]       tb_seq;

  mesh_term_injector_if #(.pckg_sz(PKT_W)) bus ();

  mesh_term_injector #(
    .pckg_sz(PKT_W), .fifo_depth(8), .ROWS(4), .COLUMS(4),
    .id_row(0), .id_column(0), .SEQ_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .fill_lvl     (fill_lvl),
    .sent_cnt     (sent_cnt),
    .rej_cnt      (rej_cnt),
    .err_bad_dest (err_bad_dest)
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] model_pkt(input logic [3:0] r, input logic [3:0] c,
                                                 input logic m, input logic [PW-1:0] p,
                                                 input logic [7:0] s);
    logic [PW-1:0] pl;
    pl = p;
`ifdef MESH_INJ_SEQ_STAMP_EN
    pl[7:0] = s;
`else
    pl[7:0] = p[7:0] | (s & 8'h00);
`endif
    return {8'h00, r, c, m, pl};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_vld     = 1'b0;
    bus.wr_row     = 4'd0;
    bus.wr_col     = 4'd0;
    bus.wr_mode    = 1'b0;
    bus.wr_payload = '0;
    bus.popin      = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] r, input logic [3:0] c, input logic m, input logic [PW-1:0] p);
    bus.wr_vld     = 1'b1;
    bus.wr_row     = r;
    bus.wr_col     = c;
    bus.wr_mode    = m;
    bus.wr_payload = p;
  endtask

  task automatic model_accept(input logic [3:0] r, input logic [3:0] c, input logic m, input logic [PW-1:0] p);
    exp_q.push_back(model_pkt(r, c, m, p, tb_seq));
    tb_seq = tb_seq + 8'd1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    tb_seq = 8'd0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.pndng_i_in !== 1'b0) begin fails++; $display("FAIL reset_pndng: got %b want 0", bus.pndng_i_in); end
    checks++; if (bus.data_out_i_in !== 40'h0) begin fails++; $display("FAIL reset_data: got %h want 0", bus.data_out_i_in); end
    checks++; if (bus.wr_rdy !== 1'b1) begin fails++; $display("FAIL reset_wr_rdy: got %b want 1", bus.wr_rdy); end
    checks++; if (fill_lvl !== 4'd0) begin fails++; $display("FAIL reset_fill: got %0d want 0", fill_lvl); end
    checks++; if (sent_cnt !== 16'd0) begin fails++; $display("FAIL reset_sent: got %0d want 0", sent_cnt); end
    checks++; if (rej_cnt !== 16'd0) begin fails++; $display("FAIL reset_rej: got %0d want 0", rej_cnt); end
    checks++; if (err_bad_dest !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_bad_dest); end
  endtask

  task automatic test_single();
    logic [PKT_W-1:0] lit;
    logic [PKT_W-1:0] e;
    do_reset();
    lit = {8'h00, 4'h0, 4'h1, 1'b1, 23'h012345};
`ifdef MESH_INJ_SEQ_STAMP_EN
    lit[7:0] = 8'h00;
`endif
    set_req(4'd0, 4'd1, 1'b1, 23'h012345);
    checks++; if (bus.pndng_i_in !== 1'b0) begin fails++; $display("FAIL single_no_bypass: got %b want 0", bus.pndng_i_in); end
    model_accept(4'd0, 4'd1, 1'b1, 23'h012345);
    step();
    bus.wr_vld = 1'b0;
    checks++; if (bus.pndng_i_in !== 1'b1) begin fails++; $display("FAIL single_pndng: got %b want 1", bus.pndng_i_in); end
    checks++; if (bus.data_out_i_in !== lit) begin fails++; $display("FAIL single_data: got %h want %h", bus.data_out_i_in, lit); end
    repeat (3) step();
    checks++; if (bus.pndng_i_in !== 1'b1 || bus.data_out_i_in !== lit) begin fails++; $display("FAIL single_hold: got %b/%h want 1/%h", bus.pndng_i_in, bus.data_out_i_in, lit); end
    bus.popin = 1'b1;
    e = exp_q.pop_front();
    checks++; if (bus.data_out_i_in !== e) begin fails++; $display("FAIL single_pop_data: got %h want %h", bus.data_out_i_in, e); end
    step();
    bus.popin = 1'b0;
    checks++; if (bus.pndng_i_in !== 1'b0) begin fails++; $display("FAIL single_after_pop: got %b want 0", bus.pndng_i_in); end
    checks++; if (sent_cnt !== 16'd1) begin fails++; $display("FAIL single_sent: got %0d want 1", sent_cnt); end
    // popin while empty must not count
    bus.popin = 1'b1;
    step();
    bus.popin = 1'b0;
    checks++; if (sent_cnt !== 16'd1 || bus.pndng_i_in !== 1'b0) begin fails++; $display("FAIL single_empty_pop: got %0d/%b want 1/0", sent_cnt, bus.pndng_i_in); end
  endtask

  task automatic test_fill();
    logic [PKT_W-1:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.wr_rdy !== 1'b1) begin fails++; $display("FAIL fill_rdy_%0d: got %b want 1", i, bus.wr_rdy); end
      set_req(4'd0, 4'(1 + i % 4), i[0], 23'(i * 4099 + 7));
      model_accept(4'd0, 4'(1 + i % 4), i[0], 23'(i * 4099 + 7));
      step();
    end
    idle_inputs();
    checks++; if (bus.wr_rdy !== 1'b0) begin fails++; $display("FAIL fill_full_rdy: got %b want 0", bus.wr_rdy); end
    checks++; if (fill_lvl !== 4'd8) begin fails++; $display("FAIL fill_lvl8: got %0d want 8", fill_lvl); end
    set_req(4'd5, 4'd2, 1'b0, 23'h3ABCDE);
    step();
    idle_inputs();
    checks++; if (fill_lvl !== 4'd8) begin fails++; $display("FAIL fill_overflow: got %0d want 8", fill_lvl); end
    bus.popin = 1'b1;
    e = exp_q.pop_front();
    checks++; if (bus.data_out_i_in !== e) begin fails++; $display("FAIL fill_pop_data: got %h want %h", bus.data_out_i_in, e); end
    step();
    bus.popin = 1'b0;
    checks++; if (fill_lvl !== 4'd7) begin fails++; $display("FAIL fill_lvl7: got %0d want 7", fill_lvl); end
    checks++; if (bus.wr_rdy !== 1'b1) begin fails++; $display("FAIL fill_rdy_back: got %b want 1", bus.wr_rdy); end
    checks++; if (sent_cnt !== 16'd1) begin fails++; $display("FAIL fill_sent1: got %0d want 1", sent_cnt); end
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      if (bus.pndng_i_in) begin
        bus.popin = 1'b1;
        e = exp_q.pop_front();
        checks++; if (bus.data_out_i_in !== e) begin fails++; $display("FAIL fill_drain: got %h want %h", bus.data_out_i_in, e); end
      end else begin
        bus.popin = 1'b0;
      end
      step();
    end
    bus.popin = 1'b0;
    checks++; if (exp_q.size() != 0 || bus.pndng_i_in !== 1'b0) begin fails++; $display("FAIL fill_drain_done: got %0d left/%b want 0/0", exp_q.size(), bus.pndng_i_in); end
    checks++; if (sent_cnt !== 16'd8) begin fails++; $display("FAIL fill_sent8: got %0d want 8", sent_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [PKT_W-1:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(4'(1 + i), 4'd0, 1'b1, 23'(i + 100));
      model_accept(4'(1 + i), 4'd0, 1'b1, 23'(i + 100));
      step();
    end
    checks++; if (fill_lvl !== 4'd4) begin fails++; $display("FAIL b2b_fill_start: got %0d want 4", fill_lvl); end
    for (int c = 0; c < 20; c++) begin
      set_req(4'd5, 4'(1 + c % 4), c[0], 23'(c * 77 + 1000));
      bus.popin = 1'b1;
      e = exp_q.pop_front();
      checks++; if (bus.pndng_i_in !== 1'b1 || bus.data_out_i_in !== e) begin fails++; $display("FAIL b2b_order_%0d: got %b/%h want 1/%h", c, bus.pndng_i_in, bus.data_out_i_in, e); end
      model_accept(4'd5, 4'(1 + c % 4), c[0], 23'(c * 77 + 1000));
      step();
      checks++; if (fill_lvl !== 4'd4) begin fails++; $display("FAIL b2b_fill_%0d: got %0d want 4", c, fill_lvl); end
    end
    idle_inputs();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      if (bus.pndng_i_in) begin
        bus.popin = 1'b1;
        e = exp_q.pop_front();
        checks++; if (bus.data_out_i_in !== e) begin fails++; $display("FAIL b2b_drain: got %h want %h", bus.data_out_i_in, e); end
      end else begin
        bus.popin = 1'b0;
      end
      step();
    end
    bus.popin = 1'b0;
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_drain_done: got %0d left want 0", exp_q.size()); end
    checks++; if (sent_cnt !== 16'd24) begin fails++; $display("FAIL b2b_sent: got %0d want 24", sent_cnt); end
  endtask

  typedef struct {logic [3:0] r; logic [3:0] c; logic ok;} dest_t;

  task automatic test_illegal();
    logic [PKT_W-1:0] e;
    dest_t tbl[8];
    tbl = '{'{4'd5, 4'd0, 1'b0}, '{4'd0, 4'd0, 1'b0}, '{4'd15, 4'd3, 1'b0}, '{4'd5, 4'd4, 1'b1},
            '{4'd1, 4'd0, 1'b1}, '{4'd4, 4'd5, 1'b1}, '{4'd0, 4'd5, 1'b0}, '{4'd6, 4'd1, 1'b0}};
    do_reset();
    set_req(4'd0, 4'd2, 1'b0, 23'h0055AA);
    model_accept(4'd0, 4'd2, 1'b0, 23'h0055AA);
    step();
    set_req(4'd2, 4'd2, 1'b1, 23'h7FFFFF);
    step();
    idle_inputs();
    checks++; if (err_bad_dest !== 1'b1) begin fails++; $display("FAIL ill_err_pulse: got %b want 1", err_bad_dest); end
    checks++; if (rej_cnt !== 16'd1) begin fails++; $display("FAIL ill_rej1: got %0d want 1", rej_cnt); end
    checks++; if (bus.pndng_i_in !== 1'b1 || fill_lvl !== 4'd1) begin fails++; $display("FAIL ill_not_stored: got %b/%0d want 1/1", bus.pndng_i_in, fill_lvl); end
    checks++; if (bus.data_out_i_in !== exp_q[0]) begin fails++; $display("FAIL ill_head: got %h want %h", bus.data_out_i_in, exp_q[0]); end
    step();
    checks++; if (err_bad_dest !== 1'b0) begin fails++; $display("FAIL ill_err_once: got %b want 0", err_bad_dest); end
    foreach (tbl[i]) begin
      set_req(tbl[i].r, tbl[i].c, 1'b0, 23'(i + 9000));
      if (tbl[i].ok) model_accept(tbl[i].r, tbl[i].c, 1'b0, 23'(i + 9000));
      step();
      checks++; if (err_bad_dest !== !tbl[i].ok) begin fails++; $display("FAIL ill_tbl_%0d: got %b want %b", i, err_bad_dest, !tbl[i].ok); end
    end
    idle_inputs();
    checks++; if (rej_cnt !== 16'd6) begin fails++; $display("FAIL ill_rej6: got %0d want 6", rej_cnt); end
    checks++; if (fill_lvl !== 4'd4) begin fails++; $display("FAIL ill_fill4: got %0d want 4", fill_lvl); end
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      if (bus.pndng_i_in) begin
        bus.popin = 1'b1;
        e = exp_q.pop_front();
        checks++; if (bus.data_out_i_in !== e) begin fails++; $display("FAIL ill_drain: got %h want %h", bus.data_out_i_in, e); end
      end else begin
        bus.popin = 1'b0;
      end
      step();
    end
    bus.popin = 1'b0;
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL ill_drain_done: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [PKT_W-1:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_req(4'd0, 4'(2 + i), 1'b1, 23'(i + 555));
      step();
    end
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.pndng_i_in !== 1'b0 || fill_lvl !== 4'd0 || bus.data_out_i_in !== 40'h0) begin fails++; $display("FAIL rmid_async: got %b/%0d/%h want 0/0/0", bus.pndng_i_in, fill_lvl, bus.data_out_i_in); end
    step();
    checks++; if (bus.pndng_i_in !== 1'b0 || fill_lvl !== 4'd0 || bus.wr_rdy !== 1'b1) begin fails++; $display("FAIL rmid_edge: got %b/%0d/%b want 0/0/1", bus.pndng_i_in, fill_lvl, bus.wr_rdy); end
    reset = 1'b0;
    exp_q.delete();
    tb_seq = 8'd0;
    repeat (3) step();
    checks++; if (bus.pndng_i_in !== 1'b0 || fill_lvl !== 4'd0) begin fails++; $display("FAIL rmid_stale: got %b/%0d want 0/0", bus.pndng_i_in, fill_lvl); end
    set_req(4'd5, 4'd3, 1'b0, 23'h1F0F0F);
    model_accept(4'd5, 4'd3, 1'b0, 23'h1F0F0F);
    step();
    idle_inputs();
    bus.popin = 1'b1;
    e = exp_q.pop_front();
    checks++; if (bus.pndng_i_in !== 1'b1 || bus.data_out_i_in !== e) begin fails++; $display("FAIL rmid_fresh: got %b/%h want 1/%h", bus.pndng_i_in, bus.data_out_i_in, e); end
    step();
    bus.popin = 1'b0;
    checks++; if (sent_cnt !== 16'd1 || bus.pndng_i_in !== 1'b0) begin fails++; $display("FAIL rmid_sent: got %0d/%b want 1/0", sent_cnt, bus.pndng_i_in); end
  endtask

  // Continuous stream with the head refilled straight from the request; one illegal request mid-stream.
  task automatic test_stream();
    logic [PKT_W-1:0] e;
    logic ok;
    do_reset();
    for (int i = 0; i < 259; i++) begin
      ok = (i != 100);
      if (ok) set_req(4'(1 + i % 4), 4'd5, i[1], 23'(i * 31 + 17));
      else    set_req(4'd2, 4'd2, 1'b0, 23'h000ABC);
      bus.popin = bus.pndng_i_in;
      if (bus.pndng_i_in) begin
        e = exp_q.pop_front();
        checks++; if (bus.data_out_i_in !== e) begin fails++; $display("FAIL stream_%0d: got %h want %h", i, bus.data_out_i_in, e); end
      end
      if (ok) model_accept(4'(1 + i % 4), 4'd5, i[1], 23'(i * 31 + 17));
      step();
    end
    idle_inputs();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      if (bus.pndng_i_in) begin
        bus.popin = 1'b1;
        e = exp_q.pop_front();
        checks++; if (bus.data_out_i_in !== e) begin fails++; $display("FAIL stream_drain: got %h want %h", bus.data_out_i_in, e); end
      end else begin
        bus.popin = 1'b0;
      end
      step();
    end
    bus.popin = 1'b0;
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL stream_drain_done: got %0d left want 0", exp_q.size()); end
    checks++; if (rej_cnt !== 16'd1) begin fails++; $display("FAIL stream_rej: got %0d want 1", rej_cnt); end
    checks++; if (sent_cnt !== 16'd258) begin fails++; $display("FAIL stream_sent: got %0d want 258", sent_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    tb_seq = 8'd0;
    idle_inputs();
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
